// File: rtl/demux_tdm.sv
// demux_tdm: 4-slot TDM word demultiplexer with HUNT/LOCK framing; DEMUX_ERR_CNT_EN adds a saturating err_cnt output
module demux_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       sel,
  output logic             lock,
  output logic             err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [2:0][WIDTH-1:0]   sh_q, sh_d;
  logic [3:0][WIDTH-1:0]   y_q, y_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0]              cnt_q;
`endif
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? HUNT : state_d;
  // next state: sync enters/keeps lock, missing sync at slot 0 drops back to hunt
  always_comb
    state_d = !din_valid ? state_q :
              state_q == HUNT ? (frame_sync ? LOCK : HUNT) :
              (sel_q == 2'd0 && !frame_sync) ? HUNT : LOCK;
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      sh_q  <= '0;
      y_q   <= '0;
      fv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      sh_q  <= sh_d;
      y_q   <= y_d;
      fv_q  <= fv_d;
      err_q <= err_d;
    end
  end
  // datapath next values; the slot-3 word bypasses the shadows straight into y
  always_comb begin
    sel_d = sel_q;
    sh_d  = sh_q;
    y_d   = y_q;
    fv_d  = 1'b0;
    err_d = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        sh_d[0] = din;
        sel_d   = 2'd1;
        err_d   = state_q == LOCK && sel_q != 2'd0;
      end else if (state_q == LOCK) begin
        if (sel_q == 2'd0) begin
          err_d = 1'b1;
        end else if (sel_q == 2'd3) begin
          y_d   = {din, sh_q[2], sh_q[1], sh_q[0]};
          fv_d  = 1'b1;
          sel_d = 2'd0;
        end else begin
          sh_d[1] = sel_q == 2'd1 ? din : sh_q[1];
          sh_d[2] = sel_q == 2'd2 ? din : sh_q[2];
          sel_d   = sel_q + 2'd1;
        end
      end
    end
  end
`ifdef DEMUX_ERR_CNT_EN
  // saturating count of err pulses
  always_ff @(posedge clk)
    cnt_q <= rst ? 8'd0 : (err_d && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
`endif
  // outputs
  always_comb begin
    lock        = state_q == LOCK;
    sel         = sel_q;
    frame_valid = fv_q;
    err         = err_q;
    y0          = y_q[0];
    y1          = y_q[1];
    y2          = y_q[2];
    y3          = y_q[3];
`ifdef DEMUX_ERR_CNT_EN
    err_cnt     = cnt_q;
`endif
  end
endmodule

// File: tb/tb_demux_tdm.sv
// tb_demux_tdm: directed self-checking bench for demux_tdm
module tb_demux_tdm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid, lock, err;
  logic [1:0] sel;
  int         n_chk = 0;
  int         n_fail = 0;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  demux_tdm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
    .sel(sel), .lock(lock), .err(err)
`ifdef DEMUX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic [7:0] w, input logic fs);
    rst = r;
    din_valid = v;
    din = w;
    frame_sync = fs;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
`ifdef DEMUX_ERR_CNT_EN
    chk(tag, {24'd0, err_cnt}, {24'd0, exp});
`else
    if (tag.len() < 0) $display("%0d", exp);
`endif
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h5A, 1);
    chk("rst_y", {y3, y2, y1, y0}, 32'h0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_lock", {31'd0, lock}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk_cnt("rst_cnt", 8'd0);
    // back-to-back frame
    step(0, 1, 8'h11, 1);
    chk("bb_sel1", {30'd0, sel}, 32'd1);
    chk("bb_lock", {31'd0, lock}, 32'd1);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    chk("bb_fv_early", {31'd0, frame_valid}, 32'd0);
    chk("bb_y_held", {y3, y2, y1, y0}, 32'h0);
    step(0, 1, 8'h44, 0);
    chk("bb_y", {y3, y2, y1, y0}, 32'h44332211);
    chk("bb_fv", {31'd0, frame_valid}, 32'd1);
    chk("bb_sel0", {30'd0, sel}, 32'd0);
    chk("bb_lock2", {31'd0, lock}, 32'd1);
    chk("bb_err", {31'd0, err}, 32'd0);
    step(0, 0, 8'h00, 0);
    chk("bb_fv_off", {31'd0, frame_valid}, 32'd0);
    // same frame with 3-cycle gaps
    step(0, 1, 8'h11, 1);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 8'hEE, 1);
      chk("gap_sel", {30'd0, sel}, 32'd1);
    end
    step(0, 1, 8'h22, 0);
    for (int g = 0; g < 3; g++) step(0, 0, 8'hEE, 0);
    step(0, 1, 8'h33, 0);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 8'hEE, 0);
      chk("gap_fv0", {31'd0, frame_valid}, 32'd0);
    end
    chk("gap_sel3", {30'd0, sel}, 32'd3);
    step(0, 1, 8'h44, 0);
    chk("gap_fv", {31'd0, frame_valid}, 32'd1);
    chk("gap_y", {y3, y2, y1, y0}, 32'h44332211);
    step(0, 0, 8'h00, 0);
    chk("gap_fv_off", {31'd0, frame_valid}, 32'd0);
    // missing sync at slot 0
    step(0, 1, 8'h77, 0);
    chk("nosync_err", {31'd0, err}, 32'd1);
    chk("nosync_lock", {31'd0, lock}, 32'd0);
    chk("nosync_sel", {30'd0, sel}, 32'd0);
    chk("nosync_fv", {31'd0, frame_valid}, 32'd0);
    chk("nosync_y", {y3, y2, y1, y0}, 32'h44332211);
    chk_cnt("nosync_cnt", 8'd1);
    step(0, 0, 8'h00, 0);
    chk("nosync_err_off", {31'd0, err}, 32'd0);
    // hunting discards unsynced words
    step(0, 1, 8'hAA, 0);
    chk("hunt_lock", {31'd0, lock}, 32'd0);
    step(0, 1, 8'hBB, 0);
    chk("hunt_sel", {30'd0, sel}, 32'd0);
    chk("hunt_err", {31'd0, err}, 32'd0);
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h04, 0);
    chk("hunt_y", {y3, y2, y1, y0}, 32'h04030201);
    chk("hunt_fv", {31'd0, frame_valid}, 32'd1);
    // early sync restarts the frame
    step(0, 1, 8'h10, 1);
    step(0, 1, 8'h20, 0);
    step(0, 1, 8'h30, 1);
    chk("resync_err", {31'd0, err}, 32'd1);
    chk("resync_sel", {30'd0, sel}, 32'd1);
    chk("resync_lock", {31'd0, lock}, 32'd1);
    chk("resync_y", {y3, y2, y1, y0}, 32'h04030201);
    chk_cnt("resync_cnt", 8'd2);
    step(0, 1, 8'h40, 0);
    chk("resync_err_off", {31'd0, err}, 32'd0);
    step(0, 1, 8'h50, 0);
    step(0, 1, 8'h60, 0);
    chk("resync_y2", {y3, y2, y1, y0}, 32'h60504030);
    chk("resync_fv", {31'd0, frame_valid}, 32'd1);
    chk("resync_noerr", {31'd0, err}, 32'd0);
    // reset mid-frame
    step(0, 1, 8'h91, 1);
    step(0, 1, 8'h92, 0);
    step(1, 1, 8'h93, 0);
    chk("midrst_y", {y3, y2, y1, y0}, 32'h0);
    chk("midrst_fv", {31'd0, frame_valid}, 32'd0);
    chk("midrst_lock", {31'd0, lock}, 32'd0);
    chk("midrst_sel", {30'd0, sel}, 32'd0);
    chk_cnt("midrst_cnt", 8'd0);
    step(0, 1, 8'h94, 0);
    chk("postrst_lock", {31'd0, lock}, 32'd0);
    step(0, 1, 8'hA1, 1);
    step(0, 1, 8'hA2, 0);
    step(0, 1, 8'hA3, 0);
    chk("postrst_y0", {y3, y2, y1, y0}, 32'h0);
    step(0, 1, 8'hA4, 0);
    chk("postrst_y", {y3, y2, y1, y0}, 32'hA4A3A2A1);
    chk("postrst_fv", {31'd0, frame_valid}, 32'd1);
    step(0, 0, 8'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
